// File: rtl/ddr_phase_stepper_if.sv
// Target-phase request channel for ddr_phase_stepper: valid/ready handshake
// carrying a read-clock phase index.
interface ddr_phase_stepper_if #(
  parameter int PW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic [PW-1:0] req_phase;

  modport master (output req_valid, output req_phase, input req_ready);
  modport slave  (input req_valid, input req_phase, output req_ready);
endinterface

// File: rtl/ddr_phase_stepper.sv
// DDR read-clock phase stepper. Drives phase_step/phase_updn of the PLL
// clocking block one 22.5 degree step at a time toward a requested phase
// index. After each step it waits for the PLL to relock and flags a timeout
// if relock never comes.
// Optional build macro DDR_PHASE_SHORTEST_EN: when defined, the stepper takes
// the shortest path (ties step up). When undefined, it always steps up, which
// gives monotonic sweeps for calibration.
module ddr_phase_stepper #(
  parameter int PHASE_STEPS   = 16,
  parameter int INIT_PHASE    = 4,
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 32,
  parameter int LOCK_TIMEOUT  = 1024,
  localparam int PW           = $clog2(PHASE_STEPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_locked,
  ddr_phase_stepper_if.slave   req,
  output logic                 phase_step,
  output logic                 phase_updn,
  output logic [PW-1:0]        cur_phase,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  // One counter serves pulse, settle and lock-wait phases, so size it for the
  // largest of the three.
  localparam int CMAX = (LOCK_TIMEOUT > SETTLE_CYCLES) ?
                        ((LOCK_TIMEOUT > PULSE_CYCLES) ? LOCK_TIMEOUT : PULSE_CYCLES) :
                        ((SETTLE_CYCLES > PULSE_CYCLES) ? SETTLE_CYCLES : PULSE_CYCLES);
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, CALC, PULSE, SETTLE, WAIT_LOCK} state_t;

  state_t        state, state_n;
  logic [PW-1:0] tgt, tgt_n, cur_n, diff;
  logic [CW-1:0] cnt, cnt_n;
  logic          step_n, updn_n, err_n, done_n;
  logic          lock_s1, lock_s2;
  logic          up;

  // Modular distance to the target; wraps naturally in PW bits.
  assign diff = tgt - cur_phase;

`ifdef DDR_PHASE_SHORTEST_EN
  // Step up when the target is at most half a turn ahead (tie goes up).
  assign up = ({1'b0, diff} <= (PW+1)'(PHASE_STEPS / 2));
`else
  assign up = 1'b1;
`endif

  assign busy          = (state != IDLE);
  assign req.req_ready = (state == IDLE) && !rst;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      lock_s1 <= pll_locked;
      lock_s2 <= lock_s1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tgt        <= PW'(INIT_PHASE);
      cur_phase  <= PW'(INIT_PHASE);
      cnt        <= '0;
      phase_step <= 1'b0;
      phase_updn <= 1'b1;
      error      <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      tgt        <= tgt_n;
      cur_phase  <= cur_n;
      cnt        <= cnt_n;
      phase_step <= step_n;
      phase_updn <= updn_n;
      error      <= err_n;
      done       <= done_n;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    cur_n   = cur_phase;
    cnt_n   = cnt;
    step_n  = phase_step;
    updn_n  = phase_updn;
    err_n   = error;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (req.req_valid) begin
          tgt_n   = req.req_phase;
          err_n   = 1'b0;
          state_n = CALC;
        end
      end
      CALC: begin
        if (diff == '0) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          // Direction only changes here, while phase_step is low.
          updn_n  = up;
          step_n  = 1'b1;
          cnt_n   = '0;
          state_n = PULSE;
        end
      end
      PULSE: begin
        if (cnt == CW'(PULSE_CYCLES - 1)) begin
          step_n  = 1'b0;
          cur_n   = phase_updn ? cur_phase + 1'b1 : cur_phase - 1'b1;
          cnt_n   = '0;
          state_n = SETTLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = WAIT_LOCK;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s2) begin
          state_n = CALC;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          // Give up on this request; cur_phase keeps the stepped value.
          err_n   = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ddr_phase_stepper.sv
// Directed testbench for ddr_phase_stepper (default parameters).
module tb_ddr_phase_stepper;
  localparam int PW     = 4;
  localparam int PULSE  = 4;
  localparam int SETTLE = 32;
  localparam int LT     = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic          phase_step, phase_updn, busy, done, error;
  logic [PW-1:0] cur_phase;

  ddr_phase_stepper_if #(.PW(PW)) rq ();

  ddr_phase_stepper dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .req        (rq),
    .phase_step (phase_step),
    .phase_updn (phase_updn),
    .cur_phase  (cur_phase),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitor: counts pulses, directions, widths, gaps and logs the
  // phase reported after each completed pulse.
  int            rises = 0, falls = 0, ups = 0, downs = 0;
  int            width_viol = 0, gap_viol = 0, updn_viol = 0, ready_viol = 0;
  int            hi_len = 0, lo_len = 0;
  logic          prev_step = 1'b0, prev_updn = 1'b1, seen_fall = 1'b0;
  logic [PW-1:0] plog [0:255];

  always @(negedge clk) begin
    if (phase_step && !prev_step) begin
      rises <= rises + 1;
      if (phase_updn) ups <= ups + 1; else downs <= downs + 1;
      if (seen_fall && lo_len < SETTLE + 2) gap_viol <= gap_viol + 1;
      hi_len <= 1;
    end else if (phase_step) begin
      hi_len <= hi_len + 1;
      if (phase_updn !== prev_updn) updn_viol <= updn_viol + 1;
    end
    if (!phase_step && prev_step) begin
      if (!rst) begin
        if (hi_len != PULSE) width_viol <= width_viol + 1;
        plog[falls % 256] <= cur_phase;
        falls <= falls + 1;
      end
      seen_fall <= 1'b1;
      lo_len    <= 1;
    end else if (!phase_step) begin
      lo_len <= lo_len + 1;
    end
    if (busy && rq.req_ready) ready_viol <= ready_viol + 1;
    prev_step <= phase_step;
    prev_updn <= phase_updn;
  end

  // Advance to just after the next falling edge (monitor updates settled).
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    rq.req_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b1; rq.req_valid = 1'b0; rq.req_phase = '0;
    repeat (3) tick();
    checks++;
    if (rq.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst got=%b want=0", rq.req_ready); end
    checks++;
    if (cur_phase !== 4'd4 || phase_step !== 1'b0 || phase_updn !== 1'b1) begin
      errors++; $display("FAIL reset_phase got cur=%0d step=%b updn=%b want cur=4 step=0 updn=1", cur_phase, phase_step, phase_updn);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b done=%b error=%b want 0 0 0", busy, done, error);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (rq.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b want=1", rq.req_ready); end
  endtask

  task automatic test_zero_diff();
    int r0;
    r0 = rises;
    rq.req_phase = 4'd4; rq.req_valid = 1'b1;
    tick();
    rq.req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero_calc got busy=%b done=%b want 1 0", busy, done); end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cur_phase !== 4'd4) begin
      errors++; $display("FAIL zero_done got done=%b busy=%b cur=%0d want 1 0 4", done, busy, cur_phase);
    end
    tick();
    checks++;
    if (done !== 1'b0 || rises != r0) begin errors++; $display("FAIL zero_nopulse got done=%b pulses=%0d want 0 0", done, rises - r0); end
  endtask

  // One request from start to target; expects n pulses in one direction.
  // req_valid stays high with a different phase while busy; it must be ignored.
  task automatic do_move(input logic [PW-1:0] start, input logic [PW-1:0] target,
                         input int n, input bit up, input string name);
    int r0, u0, d0, f0, t;
    bit got;
    logic [PW-1:0] p;
    r0 = rises; u0 = ups; d0 = downs; f0 = falls;
    rq.req_phase = target; rq.req_valid = 1'b1;
    tick();
    rq.req_phase = target + 4'd3;
    got = 1'b0;
    for (t = 0; t < 5000; t++) begin
      tick();
      if (done) begin got = 1'b1; break; end
    end
    rq.req_valid = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL %s done_timeout got no done want done", name); end
    checks++;
    if (cur_phase !== target || error !== 1'b0) begin
      errors++; $display("FAIL %s final got cur=%0d err=%b want cur=%0d err=0", name, cur_phase, error, target);
    end
    checks++;
    if (rises - r0 != n || ups - u0 != (up ? n : 0) || downs - d0 != (up ? 0 : n)) begin
      errors++; $display("FAIL %s pulses got n=%0d up=%0d dn=%0d want n=%0d up=%0d", name, rises - r0, ups - u0, downs - d0, n, up);
    end
    p = start;
    for (int i = 0; i < n; i++) begin
      p = up ? p + 4'd1 : p - 4'd1;
      checks++;
      if (plog[(f0 + i) % 256] !== p) begin
        errors++; $display("FAIL %s step%0d_phase got=%0d want=%0d", name, i, plog[(f0 + i) % 256], p);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s done_width got done=%b busy=%b want 0 0", name, done, busy); end
  endtask

  task automatic test_timeout();
    int r0, t;
    bit seen;
    r0 = rises;
    rq.req_phase = 4'd9; rq.req_valid = 1'b1;
    tick();
    rq.req_valid = 1'b0;
    seen = 1'b0;
    for (t = 0; t < 10; t++) begin if (phase_step) begin seen = 1'b1; break; end tick(); end
    pll_locked = 1'b0;
    for (t = 0; t < 10 && phase_step; t++) tick();
    checks++;
    if (!seen || phase_step !== 1'b0) begin errors++; $display("FAIL timeout_pulse got seen=%b step=%b want 1 0", seen, phase_step); end
    // t counts falling edges after the one following the pulse's end.
    seen = 1'b0;
    for (t = 1; t <= 1200; t++) begin
      tick();
      if (done) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || t != SETTLE + LT) begin errors++; $display("FAIL timeout_latency got=%0d want=%0d", t, SETTLE + LT); end
    checks++;
    if (error !== 1'b1 || cur_phase !== 4'd9 || rises - r0 != 1) begin
      errors++; $display("FAIL timeout_state got err=%b cur=%0d pulses=%0d want 1 9 1", error, cur_phase, rises - r0);
    end
    tick();
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky got err=%b done=%b busy=%b want 1 0 0", error, done, busy);
    end
    pll_locked = 1'b1;
    repeat (3) tick();
    rq.req_phase = 4'd10; rq.req_valid = 1'b1;
    tick();
    rq.req_valid = 1'b0;
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL timeout_clear got=%b want=0", error); end
    seen = 1'b0;
    for (t = 0; t < 500; t++) begin tick(); if (done) begin seen = 1'b1; break; end end
    checks++;
    if (!seen || cur_phase !== 4'd10 || error !== 1'b0) begin
      errors++; $display("FAIL timeout_recover got done=%b cur=%0d err=%b want 1 10 0", seen, cur_phase, error);
    end
  endtask

  task automatic test_reset_abort();
    int r0;
    bit seen;
    reset_dut();
    r0 = rises;
    rq.req_phase = 4'd10; rq.req_valid = 1'b1;
    tick();
    rq.req_phase = 4'd2;
    seen = 1'b0;
    for (int t = 0; t < 10; t++) begin if (phase_step) begin seen = 1'b1; break; end tick(); end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (!seen || phase_step !== 1'b0 || cur_phase !== 4'd4 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_state got seen=%b step=%b cur=%0d busy=%b want 1 0 4 0", seen, phase_step, cur_phase, busy);
    end
    checks++;
    if (rq.req_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b want=0", rq.req_ready); end
    rq.req_valid = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || cur_phase !== 4'd4 || rises - r0 != 1 || rq.req_ready !== 1'b1) begin
      errors++; $display("FAIL abort_after got busy=%b cur=%0d pulses=%0d ready=%b want 0 4 1 1", busy, cur_phase, rises - r0, rq.req_ready);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (width_viol != 0) begin errors++; $display("FAIL pulse_width bad_pulses=%0d want 0", width_viol); end
    checks++;
    if (gap_viol != 0) begin errors++; $display("FAIL pulse_gap short_gaps=%0d want 0", gap_viol); end
    checks++;
    if (updn_viol != 0) begin errors++; $display("FAIL updn_stable changes=%0d want 0", updn_viol); end
    checks++;
    if (ready_viol != 0) begin errors++; $display("FAIL ready_busy cycles=%0d want 0", ready_viol); end
  endtask

  initial begin
    rst = 1'b1; pll_locked = 1'b1; rq.req_valid = 1'b0; rq.req_phase = '0;
    test_reset();
    test_zero_diff();
    do_move(4'd4, 4'd6, 2, 1'b1, "up_4_6");
    reset_dut();
`ifdef DDR_PHASE_SHORTEST_EN
    do_move(4'd4, 4'd1, 3, 1'b0, "down_4_1");
    do_move(4'd1, 4'd15, 2, 1'b0, "wrap_1_15");
`else
    do_move(4'd4, 4'd1, 13, 1'b1, "up_4_1");
    do_move(4'd1, 4'd15, 14, 1'b1, "up_1_15");
`endif
    do_move(4'd15, 4'd0, 1, 1'b1, "wrap_15_0");
    do_move(4'd0, 4'd8, 8, 1'b1, "tie_0_8");
    do_move(4'd8, 4'd8, 0, 1'b1, "same_8");
    test_timeout();
    test_reset_abort();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
